// File: rtl/diploma_kinematics_top.sv
// Range-sensor kinematics datapath: UART frame parser, three-sample speed/acceleration
// filter, and result streaming over SPI (mode 0) and UART tx with a one-deep latest-wins backlog.
module diploma_kinematics_top #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DELTA_T   = 10,
    parameter int SPI_DIV   = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic rx,
    output logic tx,
    output logic sck,
    output logic mosi,
    output logic cs
);
    localparam int BAUD_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int BW = $clog2(BAUD_TICKS + 1);
    localparam int SW = $clog2(SPI_DIV + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_TICKS - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_TICKS / 2 - 1);
    localparam logic [SW-1:0] SPI_LAST  = SW'(SPI_DIV - 1);
    localparam logic signed [31:0] DT  = 32'(DELTA_T);
    localparam logic signed [31:0] DT2 = 32'(DELTA_T * DELTA_T);

    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [2:0] P_H1 = 3'd0, P_H2 = 3'd1, P_CMD = 3'd2, P_LEN = 3'd3,
                           P_DHI = 3'd4, P_DLO = 3'd5, P_STAT = 3'd6, P_CRC = 3'd7;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_TAIL = 2'd2;

    logic [1:0]    rx_state_reg;
    logic          rx_s1_reg, rx_s2_reg, rx_prev_reg;
    logic [BW-1:0] rx_cnt_reg;
    logic [2:0]    rx_bit_reg;
    logic [7:0]    rx_shift_reg;
    logic          byte_valid_reg, frame_err_reg;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rx_state_reg   <= RX_IDLE;
            rx_s1_reg      <= 1'b1;
            rx_s2_reg      <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_s1_reg      <= rx;
            rx_s2_reg      <= rx_s1_reg;
            rx_prev_reg    <= rx_s2_reg;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: if (rx_prev_reg && !rx_s2_reg) begin
                    rx_state_reg <= RX_START;
                    rx_cnt_reg   <= '0;
                end
                RX_START: if (rx_cnt_reg == HALF_LAST) begin
                    // A start bit that is high again at mid-bit was only a glitch
                    rx_cnt_reg   <= '0;
                    rx_bit_reg   <= '0;
                    rx_state_reg <= rx_s2_reg ? RX_IDLE : RX_DATA;
                end else rx_cnt_reg <= rx_cnt_reg + 1'b1;
                RX_DATA: if (rx_cnt_reg == BAUD_LAST) begin
                    rx_cnt_reg   <= '0;
                    rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
                    rx_bit_reg   <= rx_bit_reg + 1'b1;
                    if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                end else rx_cnt_reg <= rx_cnt_reg + 1'b1;
                default: if (rx_cnt_reg == BAUD_LAST) begin
                    rx_cnt_reg     <= '0;
                    rx_state_reg   <= RX_IDLE;
                    byte_valid_reg <= rx_s2_reg;
                    frame_err_reg  <= !rx_s2_reg;
                end else rx_cnt_reg <= rx_cnt_reg + 1'b1;
            endcase
        end
    end

    logic [2:0]  p_state_reg;
    logic [15:0] dist_reg;
    logic        accept_reg;
    logic [2:0]  p_miss;

    assign p_miss = (rx_shift_reg == 8'h55) ? P_H2 : P_H1;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            p_state_reg <= P_H1;
            dist_reg    <= '0;
            accept_reg  <= 1'b0;
        end else begin
            accept_reg <= 1'b0;
            if (frame_err_reg) begin
                p_state_reg <= P_H1;
            end else if (byte_valid_reg) begin
                case (p_state_reg)
                    P_H1:   p_state_reg <= p_miss;
                    P_H2:   p_state_reg <= (rx_shift_reg == 8'hAA) ? P_CMD : p_miss;
                    P_CMD:  p_state_reg <= (rx_shift_reg == 8'h81) ? P_LEN : p_miss;
                    P_LEN:  p_state_reg <= (rx_shift_reg == 8'h03) ? P_DHI : p_miss;
                    P_DHI: begin
                        dist_reg[15:8] <= rx_shift_reg;
                        p_state_reg    <= P_DLO;
                    end
                    P_DLO: begin
                        dist_reg[7:0] <= rx_shift_reg;
                        p_state_reg   <= P_STAT;
                    end
                    P_STAT: p_state_reg <= P_CRC;
                    default: begin
                        accept_reg  <= 1'b1;
                        p_state_reg <= P_H1;
                    end
                endcase
            end
        end
    end

    logic [15:0]        d1_reg, d2_reg, d3_reg;
    logic [1:0]         count_reg;
    logic               calc_reg;
    logic signed [31:0] speed_prev_reg, accel_prev_reg;
    logic signed [31:0] d1_s, d2_s, d3_s, v_raw, accel, speed_sum, speed;
    logic [31:0]        pend_word_reg;
    logic               pend_valid_reg;
    logic               launch;
    logic [1:0]         spi_state_reg;
    logic               tx_busy_reg;

    assign d1_s      = $signed({16'd0, d1_reg});
    assign d2_s      = $signed({16'd0, d2_reg});
    assign d3_s      = $signed({16'd0, d3_reg});
    assign v_raw     = (d3_s - d2_s) / DT;
    assign accel     = (d3_s - (d2_s <<< 1) + d1_s) / DT2;
    assign speed_sum = v_raw - speed_prev_reg + accel_prev_reg;
    assign speed     = speed_sum >>> 1;
    assign launch    = pend_valid_reg && (spi_state_reg == S_IDLE) && !tx_busy_reg;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            d1_reg         <= '0;
            d2_reg         <= '0;
            d3_reg         <= '0;
            count_reg      <= '0;
            calc_reg       <= 1'b0;
            speed_prev_reg <= '0;
            accel_prev_reg <= '0;
            pend_word_reg  <= '0;
            pend_valid_reg <= 1'b0;
        end else begin
            calc_reg <= 1'b0;
            if (accept_reg) begin
                d1_reg    <= d2_reg;
                d2_reg    <= d3_reg;
                d3_reg    <= dist_reg;
                count_reg <= (count_reg == 2'd3) ? 2'd3 : count_reg + 2'd1;
                calc_reg  <= (count_reg >= 2'd2);
            end
            // A fresh result always overwrites the backlog slot
            if (calc_reg) begin
                speed_prev_reg <= speed;
                accel_prev_reg <= accel;
                pend_word_reg  <= {speed[15:0], accel[15:0]};
                pend_valid_reg <= 1'b1;
            end else if (launch) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    logic [SW-1:0] spi_cnt_reg;
    logic [4:0]    spi_bit_reg;
    logic [31:0]   spi_shift_reg;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            spi_state_reg <= S_IDLE;
            spi_cnt_reg   <= '0;
            spi_bit_reg   <= '0;
            spi_shift_reg <= '0;
            sck           <= 1'b0;
            mosi          <= 1'b0;
            cs            <= 1'b1;
        end else begin
            case (spi_state_reg)
                S_IDLE: if (launch) begin
                    cs            <= 1'b0;
                    mosi          <= pend_word_reg[31];
                    spi_shift_reg <= pend_word_reg;
                    spi_cnt_reg   <= '0;
                    spi_bit_reg   <= '0;
                    spi_state_reg <= S_RUN;
                end
                S_RUN: if (spi_cnt_reg == SPI_LAST) begin
                    spi_cnt_reg <= '0;
                    if (!sck) begin
                        sck <= 1'b1;
                    end else begin
                        sck <= 1'b0;
                        if (spi_bit_reg == 5'd31) begin
                            spi_state_reg <= S_TAIL;
                        end else begin
                            spi_shift_reg <= spi_shift_reg << 1;
                            mosi          <= spi_shift_reg[30];
                            spi_bit_reg   <= spi_bit_reg + 1'b1;
                        end
                    end
                end else spi_cnt_reg <= spi_cnt_reg + 1'b1;
                S_TAIL: if (spi_cnt_reg == SPI_LAST) begin
                    cs            <= 1'b1;
                    mosi          <= 1'b0;
                    spi_cnt_reg   <= '0;
                    spi_state_reg <= S_IDLE;
                end else spi_cnt_reg <= spi_cnt_reg + 1'b1;
                default: spi_state_reg <= S_IDLE;
            endcase
        end
    end

    logic [BW-1:0] tx_cnt_reg;
    logic [3:0]    tx_bit_reg;
    logic [2:0]    tx_byte_reg;
    logic [9:0]    tx_frame_reg;
    logic [31:0]   tx_data_reg;

    // Each byte is framed as {stop, data, start} and shifted out LSB first
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            tx_busy_reg  <= 1'b0;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_byte_reg  <= '0;
            tx_frame_reg <= '1;
            tx_data_reg  <= '0;
            tx           <= 1'b1;
        end else if (!tx_busy_reg) begin
            if (launch) begin
                tx_busy_reg  <= 1'b1;
                tx_frame_reg <= {1'b1, 8'hA5, 1'b0};
                tx_data_reg  <= pend_word_reg;
                tx           <= 1'b0;
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
                tx_byte_reg  <= '0;
            end
        end else if (tx_cnt_reg == BAUD_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 4'd9) begin
                if (tx_byte_reg == 3'd4) begin
                    tx_busy_reg <= 1'b0;
                end else begin
                    tx_byte_reg  <= tx_byte_reg + 1'b1;
                    tx_frame_reg <= {1'b1, tx_data_reg[31:24], 1'b0};
                    tx_data_reg  <= {tx_data_reg[23:0], 8'h00};
                    tx           <= 1'b0;
                    tx_bit_reg   <= '0;
                end
            end else begin
                tx_bit_reg <= tx_bit_reg + 1'b1;
                tx         <= tx_frame_reg[tx_bit_reg + 4'd1];
            end
        end else begin
            tx_cnt_reg <= tx_cnt_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_diploma_kinematics_top.sv
// Directed bench for diploma_kinematics_top: drives sensor frames on rx and scoreboards
// the SPI words and UART tx bytes against expected results.
`timescale 1ns/1ps
module tb_diploma_kinematics_top;
    localparam int BAUD   = 16;
    localparam int BIT_NS = BAUD * 10;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic rx     = 1'b1;
    logic tx, sck, mosi, cs;

    diploma_kinematics_top #(
        .CLK_FREQ (1_600_000),
        .BAUD_RATE(100_000),
        .DELTA_T  (10),
        .SPI_DIV  (4)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .rx    (rx),
        .tx    (tx),
        .sck   (sck),
        .mosi  (mosi),
        .cs    (cs)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_spi[$];
    logic [7:0]  exp_tx[$];
    int epoch = 0;
    int spi_frames = 0;
    int tx_starts = 0;
    int m_d1 = 0, m_d2 = 0, m_d3 = 0, m_cnt = 0, m_sp = 0, m_ac = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BAUD);
        end
        rx = stop_bit;
        tick(BAUD);
        if (!stop_bit) begin
            rx = 1'b1;
            tick(BAUD);
        end
    endtask

    task automatic send_packet(input logic [15:0] d, input logic [7:0] cmd);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(cmd, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
    endtask

    task automatic push_result(input logic [15:0] s, input logic [15:0] a);
        exp_spi.push_back({s, a});
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(s[15:8]);
        exp_tx.push_back(s[7:0]);
        exp_tx.push_back(a[15:8]);
        exp_tx.push_back(a[7:0]);
    endtask

    task automatic model_accept(input int d, input bit push);
        int v, a, s;
        m_d1 = m_d2;
        m_d2 = m_d3;
        m_d3 = d;
        if (m_cnt < 3) m_cnt++;
        if (m_cnt == 3) begin
            v = (m_d3 - m_d2) / 10;
            a = (m_d3 - 2 * m_d2 + m_d1) / 100;
            s = (v - m_sp + m_ac) >>> 1;
            m_sp = s;
            m_ac = a;
            if (push) push_result(s[15:0], a[15:0]);
        end
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (cs !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, 32'(cs), 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_spi.size() != 0 || exp_tx.size() != 0) && n < 4000) begin
            tick(1);
            n++;
        end
        check(tag, 32'(exp_spi.size() + exp_tx.size()), 32'd0);
    endtask

    always begin : spi_mon
        int e, nb;
        logic [31:0] w;
        @(negedge cs);
        spi_frames++;
        e = epoch;
        nb = 0;
        w = '0;
        while (cs === 1'b0) begin
            @(posedge sck or posedge cs);
            if (cs === 1'b0) begin
                w = {w[30:0], mosi};
                nb++;
            end
        end
        if (e == epoch) begin
            check("spi_expected", 32'(exp_spi.size() != 0), 32'd1);
            check("spi_bits", 32'(nb), 32'd32);
            if (exp_spi.size() != 0) check("spi_word", w, exp_spi.pop_front());
        end
    end

    always begin : tx_mon
        int e;
        logic [7:0] b;
        logic sb;
        @(negedge tx);
        tx_starts++;
        e = epoch;
        #(BIT_NS / 2 + 3);
        if (tx === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                #(BIT_NS);
                b[i] = tx;
            end
            #(BIT_NS);
            sb = tx;
            if (e == epoch) begin
                check("tx_stop", 32'(sb), 32'd1);
                check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            end
        end
    end

    initial begin
        int f, t;
        #1 rst = 1'b0;
        tick(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        rst = 1'b1;
        tick(5);

        send_packet(16'd100, 8'h81); model_accept(100, 1'b0);
        send_packet(16'd180, 8'h81); model_accept(180, 1'b0);
        tick(100);
        check("no_out_first_two_spi", 32'(spi_frames), 32'd0);
        check("no_out_first_two_tx", 32'(tx_starts), 32'd0);
        send_packet(16'd380, 8'h81); model_accept(380, 1'b0);
        push_result(16'h000A, 16'h0001);
        wait_cs_low("latency_380");
        wait_drain("drain_380");

        send_packet(16'd300, 8'h81); model_accept(300, 1'b0);
        push_result(16'hFFF7, 16'hFFFE);
        wait_cs_low("latency_300");
        wait_drain("drain_300");

        send_byte(8'h55, 1'b1);
        send_packet(16'd250, 8'h81); model_accept(250, 1'b1);
        wait_cs_low("latency_resync");
        wait_drain("drain_resync");

        f = spi_frames; t = tx_starts;
        send_packet(16'd999, 8'h82);
        tick(200);
        check("bad_cmd_spi", 32'(spi_frames - f), 32'd0);
        check("bad_cmd_tx", 32'(tx_starts - t), 32'd0);
        send_packet(16'd260, 8'h81); model_accept(260, 1'b1);
        wait_cs_low("latency_260");
        wait_drain("drain_260");

        f = spi_frames;
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h81, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h90, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        tick(200);
        check("framing_dropped", 32'(spi_frames - f), 32'd0);
        send_packet(16'd420, 8'h81); model_accept(420, 1'b1);
        wait_cs_low("latency_420");
        wait_drain("drain_420");

        send_packet(16'd500, 8'h81); model_accept(500, 1'b1);
        wait_cs_low("latency_500");
        tick(40);
        epoch++;
        #1 rst = 1'b0;
        #1;
        check("abort_cs", 32'(cs), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_tx", 32'(tx), 32'd1);
        exp_spi.delete();
        exp_tx.delete();
        m_d1 = 0; m_d2 = 0; m_d3 = 0; m_cnt = 0; m_sp = 0; m_ac = 0;
        tick(3);
        rst = 1'b1;
        tick(5);

        f = spi_frames; t = tx_starts;
        send_packet(16'd600, 8'h81); model_accept(600, 1'b1);
        send_packet(16'd650, 8'h81); model_accept(650, 1'b1);
        tick(100);
        check("post_rst_no_spi", 32'(spi_frames - f), 32'd0);
        check("post_rst_no_tx", 32'(tx_starts - t), 32'd0);
        send_packet(16'd700, 8'h81); model_accept(700, 1'b1);
        wait_cs_low("latency_700");
        wait_drain("drain_700");
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
